// File: rtl/reduce_stream_engine_pkg.sv
// Shared definitions for the stream reduction engine.
//   mode_t   : reduction operator selected by cfg_mode
//   state_t  : engine control states
//   identity : neutral element of an operator at a given sample width
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_SUM = 2'd0,
        MODE_MAX = 2'd1,
        MODE_MIN = 2'd2,
        MODE_XOR = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_COMBINE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // Widest sample the identity helper can describe; callers slice down.
    localparam int unsigned MAX_W = 64;

    // MAX starts from the most-negative value, MIN from the most-positive,
    // SUM and XOR from zero.
    function automatic logic [MAX_W-1:0] identity(input mode_t mode, input int unsigned width);
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] mask;
        msb  = '0;
        mask = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            mask[i] = (i < width);
            msb[i]  = (i == width - 1);
        end
        case (mode)
            MODE_MAX: return msb;
            MODE_MIN: return mask & ~msb;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/reduce_stream_engine_if.sv
// Sample input stream and result output stream of the reduction engine.
//   in_data/in_valid/in_last/in_ready    : sample stream (ready/valid)
//   out_data/out_count/out_valid/out_ready : result stream (ready/valid)
//   slave  : engine side (consumes samples, produces results)
//   master : producer/consumer side
interface reduce_stream_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 12
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [LEN_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_valid
    );
endinterface

// File: rtl/reduce_stream_engine_alu.sv
// Combinational reduction operator y = op(a, b).
//   a, b : operands
//   mode : SUM (wrapping), signed MAX, signed MIN, bitwise XOR
//   y    : result
module reduce_op_alu
    import reduce_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  mode_t             mode,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = a ^ b;
        case (mode)
            MODE_SUM: y = a + b;
            MODE_MAX: y = ($signed(a) > $signed(b)) ? a : b;
            MODE_MIN: y = ($signed(a) < $signed(b)) ? a : b;
            default:  y = a ^ b;
        endcase
    end
endmodule

// File: rtl/reduce_stream_engine.sv
// Block reducer: folds each block of cfg_len samples (or up to in_last)
// into one result using LANES round-robin partial accumulators, then
// combines the lanes one per cycle and presents the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_mode   : operator, sampled on the first beat of a block
//   cfg_len    : block length (0 treated as 1), sampled on the first beat
//   strm       : sample input and result output streams
//   busy       : engine is not idle
module reduce_stream_engine
    import reduce_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned LEN_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_W-1:0]      cfg_len,
    reduce_stream_engine_if.slave strm,
    output logic                  busy
);
    localparam int unsigned LG     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CIDX_W = LG + 1;

    state_t            state;
    mode_t             mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] lanes [LANES];
    logic [DATA_W-1:0] res;
    logic [CIDX_W-1:0] cidx;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [DATA_W-1:0] out_data_q;
    logic [LEN_W-1:0]  out_count_q;

    mode_t             cfg_mode_e;
    mode_t             upd_mode;
    logic              accept;
    logic [LEN_W-1:0]  len_eff;
    logic [LG-1:0]     lane_sel;
    logic [LG-1:0]     cmb_sel;
    logic [MAX_W-1:0]  id_full;
    logic [DATA_W-1:0] id_val;
    logic [DATA_W-1:0] upd_a;
    logic [DATA_W-1:0] upd_y;
    logic [DATA_W-1:0] cmb_y;

    always_comb begin
        cfg_mode_e = mode_t'(cfg_mode);
        len_eff    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        accept     = strm.in_valid && in_ready_q;
        lane_sel   = (LANES == 1) ? '0 : count[LG-1:0];
        cmb_sel    = (LANES == 1) ? '0 : cidx[LG-1:0];
        upd_mode   = (state == S_IDLE) ? cfg_mode_e : mode_q;
        id_full    = identity(cfg_mode_e, DATA_W);
        id_val     = id_full[DATA_W-1:0];
        // The first beat of a block folds into a fresh identity, not the stale lane.
        upd_a      = (state == S_IDLE) ? id_val : lanes[lane_sel];
    end

    reduce_op_alu #(.DATA_W(DATA_W)) u_upd_alu (
        .a    (upd_a),
        .b    (strm.in_data),
        .mode (upd_mode),
        .y    (upd_y)
    );

    reduce_op_alu #(.DATA_W(DATA_W)) u_cmb_alu (
        .a    (res),
        .b    (lanes[cmb_sel]),
        .mode (mode_q),
        .y    (cmb_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= MODE_SUM;
            len_q       <= '0;
            count       <= '0;
            res         <= '0;
            cidx        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            for (int unsigned i = 0; i < LANES; i++) lanes[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q <= cfg_mode_e;
                        len_q  <= len_eff;
                        count  <= LEN_W'(1);
                        busy_q <= 1'b1;
                        for (int unsigned i = 0; i < LANES; i++) lanes[i] <= id_val;
                        lanes[0] <= upd_y;
                        if (strm.in_last || (len_eff == LEN_W'(1))) begin
                            state      <= S_COMBINE;
                            in_ready_q <= 1'b0;
                            cidx       <= '0;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        lanes[lane_sel] <= upd_y;
                        count           <= count + 1'b1;
                        if (strm.in_last || ((count + 1'b1) == len_q)) begin
                            state      <= S_COMBINE;
                            in_ready_q <= 1'b0;
                            cidx       <= '0;
                        end
                    end
                end
                S_COMBINE: begin
                    // LANES fold cycles into res, then one cycle to publish it.
                    if (cidx == CIDX_W'(LANES)) begin
                        out_data_q  <= res;
                        out_count_q <= count;
                        out_valid_q <= 1'b1;
                        state       <= S_OUTPUT;
                    end else begin
                        res  <= (cidx == '0) ? lanes[0] : cmb_y;
                        cidx <= cidx + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (strm.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_count = out_count_q;
    assign busy           = busy_q;

endmodule
